linha_envase: RTL and testbench

Parametrised bottling-line sequencer: the single-FSM successor to the fixed control/process/dispenser trio. It runs a batch of BATCH bottles through convey → fill → cap → eject, with fill and cap timeouts, a cap-magazine check and a coded fault state. It also drives a remaining-count value for the 7-segment decoder and a progress LED bar. It sits between the synchronised plant sensors and the actuator/display outputs of the automation top level.

---
 rtl/linha_envase.sv | 156 +++++++++++++++
 tb/tb_linha_envase.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/linha_envase.sv
// rtl/linha_envase.sv - bottling-line batch sequencer (convey, fill, cap, eject)
// Single Moore FSM with shared timeout timer, coded faults and progress display.
module linha_envase #(
  parameter int BATCH        = 10,
  parameter int CNT_W        = 4,
  parameter int TMR_W        = 8,
  parameter int FILL_TIMEOUT = 200,
  parameter int CAP_TIMEOUT  = 50,
  parameter int LEDS         = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             ack,
  input  logic             PG,
  input  logic             CH,
  input  logic             RO,
  input  logic             MC,
  output logic             M,
  output logic             VE,
  output logic             AD,
  output logic             A,
  output logic             busy,
  output logic             done,
  output logic [1:0]       fault_code,
  output logic [CNT_W-1:0] remaining,
  output logic [LEDS-1:0]  leds_bar
);

  typedef enum logic [2:0] {
    S_IDLE, S_CONVEY, S_FILL, S_CAP, S_EJECT, S_DONE, S_FAULT
  } state_e;

  localparam logic [TMR_W-1:0] FILL_LAST = TMR_W'(FILL_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] CAP_LAST  = TMR_W'(CAP_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] BATCH_V   = CNT_W'(BATCH);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   remaining_q, remaining_d;
  logic [CNT_W-1:0]   completed_q, completed_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [1:0]         fault_q, fault_d;
  logic               m_q, m_d, ve_q, ve_d, ad_q, ad_d, a_q, a_d;
  logic               busy_q, busy_d, done_q, done_d;
  logic [LEDS-1:0]    leds_q, leds_d;

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    completed_d = completed_q;
    timer_d     = timer_q;
    fault_d     = fault_q;
    unique case (state_q)
      S_IDLE: if (start) begin
        remaining_d = BATCH_V;
        completed_d = '0;
        fault_d     = 2'd0;
        state_d     = S_CONVEY;
      end
      S_CONVEY:
        if (stop) state_d = S_IDLE;
        else if (PG) begin
          timer_d = '0;
          state_d = S_FILL;
        end
      S_FILL:
        if (stop) state_d = S_IDLE;
        else if (CH) begin
          timer_d = '0;
          state_d = S_CAP;
        end else if (timer_q == FILL_LAST) begin
          fault_d = 2'd1;
          state_d = S_FAULT;
        end else timer_d = timer_q + TMR_W'(1);
      S_CAP:
        // An empty magazine outranks a seated cap on the same cycle.
        if (stop) state_d = S_IDLE;
        else if (!MC) begin
          fault_d = 2'd2;
          state_d = S_FAULT;
        end else if (RO) state_d = S_EJECT;
        else if (timer_q == CAP_LAST) begin
          fault_d = 2'd3;
          state_d = S_FAULT;
        end else timer_d = timer_q + TMR_W'(1);
      S_EJECT:
        if (stop) state_d = S_IDLE;
        else if (!PG) begin
          remaining_d = remaining_q - CNT_W'(1);
          completed_d = completed_q + CNT_W'(1);
          state_d     = (remaining_q == CNT_W'(1)) ? S_DONE : S_CONVEY;
        end
      S_DONE:  state_d = S_IDLE;
      S_FAULT: if (ack) begin
        fault_d = 2'd0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with it.
  always_comb begin
    m_d    = (state_d == S_CONVEY) || (state_d == S_EJECT);
    ve_d   = (state_d == S_FILL);
    ad_d   = (state_d == S_CAP) && MC;
    a_d    = (state_d == S_FAULT);
    busy_d = (state_d == S_CONVEY) || (state_d == S_FILL) ||
             (state_d == S_CAP) || (state_d == S_EJECT);
    done_d = (state_d == S_DONE);
    leds_d = '0;
    for (int i = 0; i < LEDS; i++) leds_d[i] = (int'(completed_d) > i);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      remaining_q <= '0;
      completed_q <= '0;
      timer_q     <= '0;
      fault_q     <= 2'd0;
      m_q         <= 1'b0;
      ve_q        <= 1'b0;
      ad_q        <= 1'b0;
      a_q         <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      leds_q      <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      completed_q <= completed_d;
      timer_q     <= timer_d;
      fault_q     <= fault_d;
      m_q         <= m_d;
      ve_q        <= ve_d;
      ad_q        <= ad_d;
      a_q         <= a_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      leds_q      <= leds_d;
    end
  end

  assign M          = m_q;
  assign VE         = ve_q;
  assign AD         = ad_q;
  assign A          = a_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign fault_code = fault_q;
  assign remaining  = remaining_q;
  assign leds_bar   = leds_q;

endmodule

// File: tb/tb_linha_envase.sv
// tb/tb_linha_envase.sv - directed bench for linha_envase with BATCH=3
// Outputs are checked 1 time unit after each rising edge.
module tb_linha_envase;

  logic clk = 1'b0;
  logic reset, start, stop, ack, PG, CH, RO, MC;
  logic M, VE, AD, A, busy, done;
  logic [1:0] fault_code;
  logic [3:0] remaining;
  logic [9:0] leds_bar;
  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  linha_envase #(
    .BATCH(3), .CNT_W(4), .TMR_W(8), .FILL_TIMEOUT(200), .CAP_TIMEOUT(50), .LEDS(10)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .ack(ack),
    .PG(PG), .CH(CH), .RO(RO), .MC(MC),
    .M(M), .VE(VE), .AD(AD), .A(A), .busy(busy), .done(done),
    .fault_code(fault_code), .remaining(remaining), .leds_bar(leds_bar)
  );

  // {M, VE, AD, A, busy, done}
  wire [5:0] outs = {M, VE, AD, A, busy, done};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; stop = 1'b0; ack = 1'b0;
    PG = 1'b0; CH = 1'b0; RO = 1'b0; MC = 1'b1;
    step(); step();
    chk("reset_outs", 32'(outs), 32'b000000);
    chk("reset_rem", 32'(remaining), 32'd0);
    chk("reset_leds", 32'(leds_bar), 32'd0);
    chk("reset_fc", 32'(fault_code), 32'd0);

    // Full batch of 3 with immediately responding sensors
    reset = 1'b0; start = 1'b1; step(); start = 1'b0;
    chk("b_convey", 32'(outs), 32'b100010);
    chk("b_rem3", 32'(remaining), 32'd3);
    for (int b = 0; b < 3; b++) begin
      PG = 1'b1; step();
      chk("b_fill", 32'(outs), 32'b010010);
      CH = 1'b1; RO = 1'b1; step();
      chk("b_cap", 32'(outs), 32'b001010);
      step();
      chk("b_eject", 32'(outs), 32'b100010);
      PG = 1'b0; step();
      chk("b_rem", 32'(remaining), 32'(2 - b));
      chk("b_leds", 32'(leds_bar), 32'((1 << (b + 1)) - 1));
      if (b < 2) chk("b_next_convey", 32'(outs), 32'b100010);
      else       chk("b_done", 32'(outs), 32'b000001);
    end
    step();
    chk("b_idle", 32'(outs), 32'b000000);
    chk("b_leds_final", 32'(leds_bar), 32'b0000000111);
    CH = 1'b0; RO = 1'b0;

    // Fill timeout after exactly 200 cycles in FILL
    start = 1'b1; step(); start = 1'b0;
    PG = 1'b1; step();
    repeat (199) step();
    chk("ft_still_fill", 32'(outs), 32'b010010);
    step();
    chk("ft_fault", 32'(outs), 32'b000100);
    chk("ft_code", 32'(fault_code), 32'd1);
    stop = 1'b1; step(); stop = 1'b0;
    chk("ft_stop_ignored", 32'(outs), 32'b000100);
    ack = 1'b1; step(); ack = 1'b0;
    chk("ft_ack_idle", 32'(outs), 32'b000000);
    chk("ft_ack_code", 32'(fault_code), 32'd0);
    chk("ft_rem_kept", 32'(remaining), 32'd3);

    // Empty magazine on CAP entry, with RO also high
    start = 1'b1; step(); start = 1'b0;
    step();
    CH = 1'b1; MC = 1'b0; RO = 1'b1; step();
    chk("mc_cap_no_ad", 32'(outs), 32'b000010);
    step();
    chk("mc_fault", 32'(outs), 32'b000100);
    chk("mc_code", 32'(fault_code), 32'd2);
    ack = 1'b1; step(); ack = 1'b0;
    CH = 1'b0; RO = 1'b0; MC = 1'b1;

    // Cap timeout after 50 CAP cycles
    start = 1'b1; step(); start = 1'b0;
    step();
    CH = 1'b1; step(); CH = 1'b0;
    chk("ct_cap", 32'(outs), 32'b001010);
    repeat (49) step();
    chk("ct_still_cap", 32'(outs), 32'b001010);
    step();
    chk("ct_fault", 32'(outs), 32'b000100);
    chk("ct_code", 32'(fault_code), 32'd3);
    ack = 1'b1; step(); ack = 1'b0;

    // CH arrives on the last fill cycle: CH wins
    start = 1'b1; step(); start = 1'b0;
    step();
    repeat (199) step();
    CH = 1'b1; step();
    chk("co_cap", 32'(outs), 32'b001010);
    chk("co_code", 32'(fault_code), 32'd0);
    RO = 1'b1; step();
    chk("co_eject", 32'(outs), 32'b100010);
    PG = 1'b0; step();
    chk("co_rem", 32'(remaining), 32'd2);
    chk("co_leds", 32'(leds_bar), 32'd1);
    CH = 1'b0; RO = 1'b0;

    // Stop in FILL of bottle 2, then restart
    PG = 1'b1; step();
    chk("st_fill", 32'(outs), 32'b010010);
    stop = 1'b1; step(); stop = 1'b0;
    chk("st_idle", 32'(outs), 32'b000000);
    chk("st_rem", 32'(remaining), 32'd2);
    chk("st_leds", 32'(leds_bar), 32'd1);
    start = 1'b1; step(); start = 1'b0;
    chk("st_restart", 32'(outs), 32'b100010);
    chk("st_reload", 32'(remaining), 32'd3);
    chk("st_leds_clr", 32'(leds_bar), 32'd0);

    // Reset pulsed in EJECT
    step();
    CH = 1'b1; step();
    RO = 1'b1; step();
    chk("rs_eject", 32'(outs), 32'b100010);
    reset = 1'b1; step(); reset = 1'b0;
    chk("rs_outs", 32'(outs), 32'b000000);
    chk("rs_rem", 32'(remaining), 32'd0);
    chk("rs_leds", 32'(leds_bar), 32'd0);
    step();
    chk("rs_idle_hold", 32'(outs), 32'b000000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
